// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle core controller.
package cpu_ctrl_pkg;

  // Controller state encoding. The numeric values are visible on the state port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERROR  = 3'd7
  } state_e;

  // Opcodes (instruction[31:26]) that the controller distinguishes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b000110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operation select.
  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_OPCODE = 2'b11
  } alu_op_e;

  // PC source select.
  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_src_e;

  localparam int unsigned WAIT_MAX_DEFAULT = 15;

  // Loads and stores go through the MEM state; everything else does not.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded-wait timer shared by the instruction and data memory handshakes.
// Reloaded on entry to a waiting state, it counts down once per waiting cycle
// and flags the last cycle in which an ack can still be accepted.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic active_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  // Loaded with WAIT_MAX-1 so that the count reaches zero in wait cycle WAIT_MAX.
  localparam logic [CNT_W-1:0] LOAD_VAL = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;
  localparam logic ENABLED = (WAIT_MAX != 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on entry, count down while waiting, hold at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD_VAL;
    end else if (active_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count while waiting: this is the final cycle an ack is honoured.
  assign timeout_o = ENABLED && active_i && (cnt_q == '0);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences each instruction through fetch, decode,
// execute, memory and writeback, with bounded-wait memory handshakes.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start, all strobes low
//   FETCH  | imem request held until ack; ack loads IR and PC+4
//   DECODE | capture opcode; jumps retire here, HALT parks the core
//   EXEC   | ALU step; BEQ resolves and retires here
//   MEM    | dmem request held until ack; SW retires here, LW goes on
//   WB     | register file write, retires
//   HALT   | halted, sticky until reset
//   ERROR  | memory timeout trap, sticky until reset
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [5:0]  op_i,
  input  logic        r_i,
  input  logic        i_i,
  input  logic        j_i,
  input  logic        alu_zero_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  output logic        imem_req_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        halted_o,
  output logic        error_o,
  output logic [2:0]  state_o,
  output logic [31:0] retired_o
);

  state_e      state_q;
  state_e      state_d;
  logic [5:0]  op_q;
  logic [5:0]  op_d;
  logic        r_q;
  logic        r_d;
  logic        i_q;
  logic        i_d;
  logic [31:0] retired_q;
  logic [31:0] retired_d;

  logic        retire;
  logic        timer_clear;
  logic        timer_active;
  logic        timeout;
  logic        alu_uses_funct;

  // The decoder's class flags are trusted; if it flags neither R nor I the
  // opcode alone decides whether the ALU follows the funct field.
  assign alu_uses_funct = r_q || (!i_q && (op_q == OP_RTYPE));

  assign timer_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_clear  = (state_d != state_q) &&
                        ((state_d == ST_FETCH) || (state_d == ST_MEM));

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .active_i  (timer_active),
    .timeout_o (timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and retire decision; an ack always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_DECODE: begin
        if (op_i == OP_HALT) begin
          state_d = ST_HALT;
        end else if (j_i) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_BEQ) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else if (is_mem_op(op_q)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack_i) begin
          if (op_q == OP_SW) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output strobes decoded from the current state.
  always_comb begin
    imem_req_o   = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SRC_SEQ;
    alu_op_o     = ALU_ADD;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    halted_o     = 1'b0;
    error_o      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
        end
      end
      ST_DECODE: begin
        if ((op_i != OP_HALT) && j_i) begin
          pc_write_o = 1'b1;
          pc_src_o   = PC_SRC_JUMP;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_BEQ) begin
          alu_op_o = ALU_SUB;
          if (alu_zero_i) begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_SRC_BRANCH;
          end
        end else if (is_mem_op(op_q)) begin
          alu_op_o = ALU_ADD;
        end else if (alu_uses_funct) begin
          alu_op_o = ALU_FUNCT;
        end else begin
          alu_op_o = ALU_OPCODE;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (op_q == OP_SW);
      end
      ST_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_q == OP_RTYPE);
        mem_to_reg_o = (op_q == OP_LW);
      end
      ST_HALT:  halted_o = 1'b1;
      ST_ERROR: error_o  = 1'b1;
      default: ;
    endcase
  end

  // Next values for the opcode/class latch and the retire counter.
  always_comb begin
    op_d      = op_q;
    r_d       = r_q;
    i_d       = i_q;
    retired_d = retired_q;
    if (state_q == ST_DECODE) begin
      op_d = op_i;
      r_d  = r_i;
      i_d  = i_i;
    end
    if (retire) begin
      retired_d = retired_q + 32'd1;
    end
  end

  // Opcode/class latch and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      r_q       <= 1'b0;
      i_q       <= 1'b0;
      retired_q <= '0;
    end else begin
      op_q      <= op_d;
      r_q       <= r_d;
      i_q       <= i_d;
      retired_q <= retired_d;
    end
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: instructions are queued with
// their expected per-instruction behaviour; a monitor closes a record each
// time the controller finishes an instruction (or traps) and compares it.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int WAIT_MAX = 15;
  localparam int NEVER    = 1000;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3;
  localparam int S_MEM = 4, S_WB = 5, S_HALT = 6, S_ERROR = 7;

  localparam logic [5:0] O_R = 6'b000000, O_JAL = 6'b000001, O_J = 6'b000010;
  localparam logic [5:0] O_BEQ = 6'b000100, O_ORI = 6'b000101, O_ANDI = 6'b000110;
  localparam logic [5:0] O_LW = 6'b100011, O_SW = 6'b101011, O_HALT = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  op = '0;
  logic        r = 1'b0, i = 1'b0, j = 1'b0, alu_zero = 1'b0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, ir_write, pc_write, reg_write, reg_dst, mem_to_reg;
  logic        dmem_req, dmem_we, halted, error;
  logic [1:0]  pc_src, alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  multicycle_controller #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .r_i(r), .i_i(i), .j_i(j),
    .alu_zero_i(alu_zero), .imem_ack_i(imem_ack), .dmem_ack_i(dmem_ack),
    .imem_req_o(imem_req), .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .alu_op_o(alu_op), .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .halted_o(halted), .error_o(error),
    .state_o(state), .retired_o(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    bit r, i, j, z;
    int iw, dw;   // wait cycles before the imem/dmem ack (>= WAIT_MAX: never in time)
  } instr_t;

  typedef struct {
    int cycles, ir_writes, pc_writes, last_src, alu_exec, stray;
    int reg_writes, reg_dst, m2r, dmem_cycles, dmem_we, retire, end_st;
  } rec_t;

  instr_t stim_q[$];
  rec_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [5:0] o, input bit z, input int iw, input int dw);
    instr_t t;
    t.op = o;
    t.r  = (o == O_R);
    t.j  = (o == O_J) || (o == O_JAL);
    t.i  = !t.r && !t.j;
    t.z  = z;
    t.iw = iw;
    t.dw = dw;
    return t;
  endfunction

  // Expected behaviour of one instruction, from the cycle budget of each class.
  function automatic rec_t model(input instr_t t);
    rec_t e = '{default: 0};
    e.end_st = S_FETCH;
    if (t.iw >= WAIT_MAX) begin
      e.cycles = WAIT_MAX;
      e.end_st = S_ERROR;
      return e;
    end
    e.cycles = t.iw + 2;
    e.ir_writes = 1;
    e.pc_writes = 1;
    if (t.op == O_HALT) begin
      e.end_st = S_HALT;
      return e;
    end
    if (t.j) begin
      e.pc_writes = 2;
      e.last_src = 2;
      e.retire = 1;
      return e;
    end
    e.cycles += 1;
    e.retire = 1;
    if (t.op == O_BEQ) begin
      e.alu_exec = 1;
      if (t.z) begin
        e.pc_writes = 2;
        e.last_src = 1;
      end
    end else if (t.op == O_LW || t.op == O_SW) begin
      if (t.dw >= WAIT_MAX) begin
        e.cycles += WAIT_MAX;
        e.dmem_cycles = WAIT_MAX;
        e.dmem_we = (t.op == O_SW) ? WAIT_MAX : 0;
        e.retire = 0;
        e.end_st = S_ERROR;
        return e;
      end
      e.cycles += t.dw + 1;
      e.dmem_cycles = t.dw + 1;
      if (t.op == O_SW) e.dmem_we = t.dw + 1;
      if (t.op == O_LW) begin
        e.cycles += 1;
        e.reg_writes = 1;
        e.m2r = 1;
      end
    end else begin
      e.alu_exec = (t.op == O_R) ? 2 : 3;
      e.cycles += 1;
      e.reg_writes = 1;
      e.reg_dst = (t.op == O_R) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic issue(input instr_t t, input bit expect_it);
    rec_t e;
    stim_q.push_back(t);
    if (expect_it) begin
      e = model(t);
      exp_q.push_back(e);
    end
  endtask

  // Memory responder / decoder stand-in: presents the next queued instruction
  // at the start of each fetch and acks each request after its wait count.
  instr_t cur;
  int     icnt, dcnt, drv_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      icnt = 0; dcnt = 0; drv_prev = S_IDLE;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      cur = mk(O_R, 1'b0, NEVER, NEVER);
    end else begin
      if (int'(state) == S_FETCH && drv_prev != S_FETCH) begin
        if (stim_q.size() > 0) cur = stim_q.pop_front();
        else cur = mk(O_R, 1'b0, NEVER, NEVER);
        op = cur.op; r = cur.r; i = cur.i; j = cur.j; alu_zero = cur.z;
      end
      if (imem_req) icnt++; else icnt = 0;
      if (dmem_req) dcnt++; else dcnt = 0;
      imem_ack = imem_req && (icnt == cur.iw + 1);
      dmem_ack = dmem_req && (dcnt == cur.dw + 1);
      drv_prev = int'(state);
    end
  end

  // Monitor: accumulates observed strobes per instruction and checks each
  // completed record against the head of the scoreboard.
  initial begin : monitor
    rec_t acc, e;
    int   prev_st, st, ret_start;
    bit   open;
    prev_st = S_IDLE; open = 0; ret_start = 0;
    acc = '{default: 0};
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        open = 0;
        prev_st = S_IDLE;
        continue;
      end
      st = int'(state);
      if (open && st != prev_st && (st == S_FETCH || st == S_HALT || st == S_ERROR)) begin
        acc.retire = int'(retired) - ret_start;
        acc.end_st = st;
        open = 0;
        chk("sb_has_entry", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cycles", acc.cycles, e.cycles);
          chk("ir_writes", acc.ir_writes, e.ir_writes);
          chk("pc_writes", acc.pc_writes, e.pc_writes);
          chk("pc_src", acc.last_src, e.last_src);
          chk("alu_op_exec", acc.alu_exec, e.alu_exec);
          chk("stray_strobes", acc.stray, 0);
          chk("reg_writes", acc.reg_writes, e.reg_writes);
          chk("reg_dst", acc.reg_dst, e.reg_dst);
          chk("mem_to_reg", acc.m2r, e.m2r);
          chk("dmem_req_cycles", acc.dmem_cycles, e.dmem_cycles);
          chk("dmem_we_cycles", acc.dmem_we, e.dmem_we);
          chk("retire_delta", acc.retire, e.retire);
          chk("end_state", acc.end_st, e.end_st);
        end
      end
      if (st == S_FETCH && prev_st != S_FETCH) begin
        open = 1;
        acc = '{default: 0};
        ret_start = int'(retired);
      end
      if (open) begin
        acc.cycles++;
        if (ir_write) acc.ir_writes++;
        if (pc_write) begin
          acc.pc_writes++;
          if (st != S_FETCH) acc.last_src = int'(pc_src);
        end
        if (st == S_EXEC) acc.alu_exec = int'(alu_op);
        else if (alu_op != 2'b00) acc.stray++;
        if (reg_write) acc.reg_writes++;
        if (reg_write && reg_dst) acc.reg_dst++;
        if (reg_write && mem_to_reg) acc.m2r++;
        if (dmem_req) acc.dmem_cycles++;
        if (dmem_req && dmem_we) acc.dmem_we++;
        if ((!reg_write && (reg_dst || mem_to_reg)) || (!dmem_req && dmem_we) ||
            (!pc_write && pc_src != 2'b00) || (st == S_FETCH && pc_write && pc_src != 2'b00) ||
            ((st == S_FETCH) != imem_req) || halted || error)
          acc.stray++;
      end
      prev_st = st;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(state), s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus.
  initial begin : stimulus
    logic [5:0] ops [8];
    int   n_ret;
    logic [5:0] o;
    ops = '{O_R, O_J, O_JAL, O_BEQ, O_ORI, O_ANDI, O_LW, O_SW};

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), S_IDLE);
    chk("reset_retired", int'(retired), 0);
    chk("reset_strobes", int'({imem_req, ir_write, pc_write, pc_src, alu_op, reg_write, reg_dst,
                               mem_to_reg, dmem_req, dmem_we, halted, error}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_without_start", int'(state), S_IDLE);

    // Directed cases followed by a random program, ending in HALT.
    n_ret = 0;
    issue(mk(O_R, 0, 0, 0), 1);     n_ret++;
    issue(mk(O_LW, 0, 0, 3), 1);    n_ret++;
    issue(mk(O_BEQ, 1, 0, 0), 1);   n_ret++;
    issue(mk(O_BEQ, 0, 0, 0), 1);   n_ret++;
    issue(mk(O_ORI, 0, 14, 0), 1);  n_ret++;
    issue(mk(O_LW, 0, 14, 14), 1);  n_ret++;
    issue(mk(O_SW, 0, 2, 14), 1);   n_ret++;
    for (int k = 0; k < 30; k++) begin
      o = ops[$urandom_range(0, 7)];
      issue(mk(o, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4))), 1);
      n_ret++;
    end
    issue(mk(O_J, 0, 0, 0), 1);     n_ret++;
    issue(mk(O_HALT, 0, 0, 0), 1);
    pulse_start();
    wait_state(S_HALT, 3000, "reach_halt");
    chk("halted_flag", int'(halted), 1);
    chk("retired_total", int'(retired), n_ret);

    // HALT is sticky and ignores start.
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_ignores_start", int'(state), S_HALT);
    chk("halt_retired_stable", int'(retired), n_ret);
    chk("halt_no_imem_req", int'(imem_req), 0);

    // Fetch that is never acknowledged traps after WAIT_MAX cycles.
    do_reset();
    issue(mk(O_ORI, 0, NEVER, 0), 1);
    pulse_start();
    wait_state(S_ERROR, 100, "reach_error");
    chk("error_flag", int'(error), 1);
    chk("error_no_imem_req", int'(imem_req), 0);
    repeat (2) @(negedge clk);
    chk("error_sticky", int'(state), S_ERROR);

    // Reset in the middle of a store's memory wait.
    do_reset();
    chk("post_reset_error_clear", int'(error), 0);
    issue(mk(O_R, 0, 1, 0), 1);
    issue(mk(O_SW, 0, 0, NEVER), 0);
    issue(mk(O_ANDI, 0, 0, 0), 1);
    issue(mk(O_HALT, 0, 0, 0), 1);
    pulse_start();
    wait_state(S_MEM, 100, "reach_mem");
    repeat (2) @(negedge clk);
    chk("pre_rst_dmem_req", int'(dmem_req), 1);
    chk("pre_rst_dmem_we", int'(dmem_we), 1);
    chk("pre_rst_retired", int'(retired), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dmem_req_drop", int'(dmem_req), 0);
    chk("rst_state", int'(state), S_IDLE);
    chk("rst_retired", int'(retired), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_state(S_HALT, 200, "refetch_halt");
    chk("refetch_retired", int'(retired), 1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, state %0d", state);
    $fatal(1, "watchdog");
  end

endmodule
